// File: rtl/sync_pkg.sv
// Shared types, default parameters and width helpers for the sync argument mux.
package sync_pkg;

    // Default configuration of the mux.
    localparam int unsigned SYNC_NUM_CH     = 4;
    localparam int unsigned SYNC_TASK_W     = 128;
    localparam int unsigned SYNC_ARG_W      = 64;
    localparam int unsigned SYNC_ARG_LSB    = 64;
    localparam int unsigned SYNC_FIFO_DEPTH = 4;

    // Channel index width; a single channel still needs one TDEST bit.
    function automatic int unsigned sync_ch_w(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Occupancy counter width; must be able to hold the value DEPTH itself.
    function automatic int unsigned sync_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned CH_W  = sync_ch_w(SYNC_NUM_CH);
    localparam int unsigned CNT_W = sync_cnt_w(SYNC_FIFO_DEPTH);

    // FIFO entry at the default widths: source channel above the argument.
    typedef struct packed {
        logic [CH_W-1:0]       dest;
        logic [SYNC_ARG_W-1:0] arg;
    } sync_entry_t;

endpackage

// File: rtl/sync_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at a rotating
// priority pointer, which moves just past the winner when a grant is taken.
module sync_rr_arbiter
    import sync_pkg::*;
#(
    parameter int unsigned NUM_CH = SYNC_NUM_CH
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_CH-1:0]              i_req,
    input  logic                           i_en,
    output logic [NUM_CH-1:0]              o_grant,
    output logic [sync_ch_w(NUM_CH)-1:0]   o_idx
);

    localparam int unsigned PW = sync_ch_w(NUM_CH);

    logic [PW-1:0] r_ptr;
    logic          w_found;
    logic          w_take;

    assign w_take = i_en && (|i_req);

    // Grant search: first requester at or after the pointer, wrapping to 0.
    always_comb begin
        w_found = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            int unsigned k;
            k = (int'(r_ptr) + off) % NUM_CH;
            if (!w_found && i_req[k]) begin
                w_found    = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = PW'(k);
            end
        end
    end

    // Priority pointer: advance past the winner only when a grant is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_take) begin
            r_ptr <= (o_idx == PW'(NUM_CH - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sync_mux.sv
// Multi-channel sync argument mux: round-robin accepts task beats from
// NUM_CH AXI-Stream inputs, extracts the argument field, and returns it
// through a first-word-fall-through FIFO tagged with the source channel.
module sync_mux
    import sync_pkg::*;
#(
    parameter int unsigned NUM_CH     = SYNC_NUM_CH,
    parameter int unsigned TASK_W     = SYNC_TASK_W,
    parameter int unsigned ARG_W      = SYNC_ARG_W,
    parameter int unsigned ARG_LSB    = SYNC_ARG_LSB,
    parameter int unsigned FIFO_DEPTH = SYNC_FIFO_DEPTH
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst,
    input  logic [NUM_CH*TASK_W-1:0]            taskIn_TDATA,
    input  logic [NUM_CH-1:0]                   taskIn_TVALID,
    output logic [NUM_CH-1:0]                   taskIn_TREADY,
    output logic [ARG_W-1:0]                    argOut_TDATA,
    output logic [sync_ch_w(NUM_CH)-1:0]        argOut_TDEST,
    output logic                                argOut_TVALID,
    input  logic                                argOut_TREADY,
    output logic [sync_cnt_w(FIFO_DEPTH)-1:0]   fifo_count
);

    localparam int unsigned DW    = sync_ch_w(NUM_CH);
    localparam int unsigned CW    = sync_cnt_w(FIFO_DEPTH);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    // Same layout as sync_entry_t, sized to this instance.
    typedef struct packed {
        logic [DW-1:0]    dest;
        logic [ARG_W-1:0] arg;
    } entry_t;

    entry_t              r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr;
    logic [PTR_W-1:0]    r_rd;
    logic [CW-1:0]       r_count;

    logic [NUM_CH-1:0]   w_grant;
    logic [DW-1:0]       w_gidx;
    logic                w_not_full;
    logic                w_accept_en;
    logic                w_push;
    logic                w_pop;
    logic [ARG_W-1:0]    w_arg;
    entry_t              w_entry;
    logic                w_unused_bits;

    // Accepting is gated only by our own occupancy (not by a pop in the same
    // cycle), so there is no combinational path from argOut_TREADY to TREADY.
    assign w_not_full  = (r_count != CW'(FIFO_DEPTH));
    assign w_accept_en = w_not_full && !ap_rst;

    sync_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_clk   (ap_clk),
        .i_rst   (ap_rst),
        .i_req   (taskIn_TVALID),
        .i_en    (w_accept_en),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    assign taskIn_TREADY = w_grant & {NUM_CH{w_accept_en}};
    assign w_push        = |taskIn_TREADY;
    assign w_pop         = argOut_TVALID && argOut_TREADY;

    // Argument field of the granted channel's beat.
    always_comb begin
        w_arg = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) begin
                w_arg = taskIn_TDATA[i*TASK_W + ARG_LSB +: ARG_W];
            end
        end
    end

    assign w_entry.dest = w_gidx;
    assign w_entry.arg  = w_arg;

    // Only the argument window of each beat is consumed.
    assign w_unused_bits = ^taskIn_TDATA;

    // FIFO storage and write pointer; cleared so outputs read zero after reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr <= '0;
        end else if (w_push) begin
            r_mem[r_wr] <= w_entry;
            r_wr        <= r_wr + 1'b1;
        end
    end

    // Read pointer: advances on each downstream handshake.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rd <= '0;
        end else if (w_pop) begin
            r_rd <= r_rd + 1'b1;
        end
    end

    // Occupancy: push and pop in the same cycle cancel.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head of FIFO drives the output directly; it only changes on a pop.
    assign argOut_TDATA  = r_mem[r_rd].arg;
    assign argOut_TDEST  = r_mem[r_rd].dest;
    assign argOut_TVALID = (r_count != '0);
    assign fifo_count    = r_count;

endmodule

// File: tb/tb_sync_mux.sv
// Directed bench for sync_mux: a round-robin vector table plus hand-written
// sequences for full/back-pressure, push/pop wrap, async reset and field offset.
module tb_sync_mux;

    logic         ap_clk = 1'b0;
    logic         ap_rst;

    // Default-parameter instance (4 channels, 128-bit beats, 64-bit arg at 64).
    logic [511:0] tdata;
    logic [3:0]   tvalid;
    logic [3:0]   tready;
    logic [63:0]  odata;
    logic [1:0]   odest;
    logic         ovalid;
    logic         ordy;
    logic [2:0]   cnt;

    // Single-channel instance with a 32-bit arg at bit 16 of a 96-bit beat.
    logic [95:0]  t2data;
    logic         t2valid;
    logic         t2ready;
    logic [31:0]  o2data;
    logic [0:0]   o2dest;
    logic         o2valid;
    logic         o2rdy;
    logic [1:0]   cnt2;

    int n_chk = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    sync_mux #(
        .NUM_CH     (4),
        .TASK_W     (128),
        .ARG_W      (64),
        .ARG_LSB    (64),
        .FIFO_DEPTH (4)
    ) u_dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .taskIn_TDATA  (tdata),
        .taskIn_TVALID (tvalid),
        .taskIn_TREADY (tready),
        .argOut_TDATA  (odata),
        .argOut_TDEST  (odest),
        .argOut_TVALID (ovalid),
        .argOut_TREADY (ordy),
        .fifo_count    (cnt)
    );

    sync_mux #(
        .NUM_CH     (1),
        .TASK_W     (96),
        .ARG_W      (32),
        .ARG_LSB    (16),
        .FIFO_DEPTH (2)
    ) u_dut2 (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .taskIn_TDATA  (t2data),
        .taskIn_TVALID (t2valid),
        .taskIn_TREADY (t2ready),
        .argOut_TDATA  (o2data),
        .argOut_TDEST  (o2dest),
        .argOut_TVALID (o2valid),
        .argOut_TREADY (o2rdy),
        .fifo_count    (cnt2)
    );

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] e_trdy;
        logic       e_tvalid;
        logic [1:0] e_dest;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Beat carrying arg in the upper half and its complement below it.
    task automatic set_ch(input int ch, input logic [63:0] arg);
        tdata[ch*128 +: 128] = {arg, ~arg};
    endtask

    function automatic logic [63:0] rr_arg(input int ch);
        return 64'hC0DE_0000_0000_0000 + 64'(ch);
    endfunction

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] q[$];
        logic [63:0] drain [4];

        ap_rst  = 1'b1;
        tvalid  = 4'hF;
        ordy    = 1'b0;
        tdata   = '0;
        for (int i = 0; i < 4; i++) set_ch(i, rr_arg(i));
        t2data  = '0;
        t2valid = 1'b1;
        o2rdy   = 1'b0;

        // Reset state, with requests present while reset is held.
        @(negedge ap_clk);
        #1;
        chk("rst_tready", tready, 4'h0);
        chk("rst_tvalid", ovalid, 1'b0);
        chk("rst_tdata", odata, 64'h0);
        chk("rst_tdest", odest, 2'd0);
        chk("rst_count", cnt, 3'd0);
        chk("rst_tready2", t2ready, 1'b0);
        t2valid = 1'b0;
        tvalid  = 4'h0;

        // Single-channel pass on ch0.
        do_reset();
        set_ch(0, 64'hDEAD_BEEF_0000_0001);
        tvalid = 4'h1;
        ordy   = 1'b1;
        #1 chk("single_tready", tready, 4'h1);
        @(negedge ap_clk);
        tvalid = 4'h0;
        #1;
        chk("single_tvalid", ovalid, 1'b1);
        chk("single_tdata", odata, 64'hDEAD_BEEF_0000_0001);
        chk("single_tdest", odest, 2'd0);
        chk("single_count", cnt, 3'd1);
        @(negedge ap_clk);
        #1 chk("single_drained", ovalid, 1'b0);

        // Round-robin table: continuous and sparse request patterns.
        tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 3'd0};
        tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 3'd1};
        tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 3'd1};
        tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 3'd1};
        tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 3'd1};
        tbl[5]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 3'd1};
        tbl[6]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 3'd1};
        tbl[7]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 3'd1};
        tbl[8]  = '{4'hA, 1'b1, 4'h2, 1'b1, 2'd3, 3'd1};
        tbl[9]  = '{4'hA, 1'b1, 4'h8, 1'b1, 2'd1, 3'd1};
        tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 3'd1};
        tbl[11] = '{4'h4, 1'b1, 4'h4, 1'b0, 2'd0, 3'd0};
        tbl[12] = '{4'h1, 1'b1, 4'h1, 1'b1, 2'd2, 3'd1};
        tbl[13] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 3'd1};
        tbl[14] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 3'd0};

        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, rr_arg(i));
        for (int r = 0; r < 15; r++) begin
            tvalid = tbl[r].valid;
            ordy   = tbl[r].ordy;
            #1;
            chk($sformatf("rr%0d_tready", r), tready, tbl[r].e_trdy);
            chk($sformatf("rr%0d_tvalid", r), ovalid, tbl[r].e_tvalid);
            chk($sformatf("rr%0d_count", r), cnt, tbl[r].e_cnt);
            if (tbl[r].e_tvalid) begin
                chk($sformatf("rr%0d_tdest", r), odest, tbl[r].e_dest);
                chk($sformatf("rr%0d_tdata", r), odata, rr_arg(int'(tbl[r].e_dest)));
            end
            @(negedge ap_clk);
        end
        tvalid = 4'h0;

        // Back-pressure until full, head held stable, single pop frees one slot.
        do_reset();
        ordy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_ch(2, 64'hB000 + 64'(k));
            tvalid = 4'h4;
            #1;
            chk($sformatf("bp%0d_tready", k), tready, (k < 4) ? 4'h4 : 4'h0);
            chk($sformatf("bp%0d_count", k), cnt, (k < 4) ? 3'(k) : 3'd4);
            if (k > 0) begin
                chk($sformatf("bp%0d_tvalid", k), ovalid, 1'b1);
                chk($sformatf("bp%0d_hold", k), odata, 64'hB000);
                chk($sformatf("bp%0d_tdest", k), odest, 2'd2);
            end
            @(negedge ap_clk);
        end
        set_ch(2, 64'hB006);
        ordy = 1'b1;
        #1;
        chk("full_pop_tready", tready, 4'h0);
        chk("full_pop_count", cnt, 3'd4);
        @(negedge ap_clk);
        ordy = 1'b0;
        #1;
        chk("after_pop_count", cnt, 3'd3);
        chk("after_pop_tready", tready, 4'h4);
        chk("after_pop_head", odata, 64'hB001);
        @(negedge ap_clk);
        tvalid = 4'h0;
        #1 chk("refill_count", cnt, 3'd4);
        drain[0] = 64'hB001; drain[1] = 64'hB002;
        drain[2] = 64'hB003; drain[3] = 64'hB006;
        ordy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 chk($sformatf("bp_drain%0d", j), odata, drain[j]);
            @(negedge ap_clk);
        end
        #1;
        chk("bp_empty_tvalid", ovalid, 1'b0);
        chk("bp_empty_count", cnt, 3'd0);

        // Simultaneous push/pop at count 2 across pointer wrap.
        do_reset();
        ordy = 1'b0;
        q.delete();
        for (int j = 0; j < 2; j++) begin
            set_ch(1, 64'hA0 + 64'(j));
            tvalid = 4'h2;
            @(negedge ap_clk);
            q.push_back(64'hA0 + 64'(j));
        end
        ordy = 1'b1;
        for (int j = 2; j < 12; j++) begin
            set_ch(1, 64'hA0 + 64'(j));
            #1;
            chk($sformatf("pp%0d_count", j), cnt, 3'd2);
            chk($sformatf("pp%0d_tready", j), tready, 4'h2);
            chk($sformatf("pp%0d_head", j), odata, q[0]);
            @(negedge ap_clk);
            void'(q.pop_front());
            q.push_back(64'hA0 + 64'(j));
        end
        tvalid = 4'h0;
        for (int j = 0; j < 2; j++) begin
            #1 chk($sformatf("pp_drain%0d", j), odata, q[0]);
            @(negedge ap_clk);
            void'(q.pop_front());
        end
        #1 chk("pp_empty", ovalid, 1'b0);

        // Async reset between edges with three entries buffered.
        do_reset();
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, rr_arg(i));
        tvalid = 4'h1;
        for (int j = 0; j < 3; j++) @(negedge ap_clk);
        tvalid = 4'hF;
        #1;
        chk("ar_pre_count", cnt, 3'd3);
        chk("ar_pre_tready", tready, 4'h2);
        #2 ap_rst = 1'b1;
        #1;
        chk("ar_tvalid", ovalid, 1'b0);
        chk("ar_count", cnt, 3'd0);
        chk("ar_tready", tready, 4'h0);
        chk("ar_tdata", odata, 64'h0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        #1 chk("ar_first_grant", tready, 4'h1);
        @(negedge ap_clk);
        tvalid = 4'h0;
        #1;
        chk("ar_first_dest", odest, 2'd0);
        chk("ar_first_count", cnt, 3'd1);

        // Field offset and single-channel degenerate case.
        t2data  = 96'hAAAA_BBBB_CCCC_1234_5678_9ABC;
        t2valid = 1'b1;
        o2rdy   = 1'b1;
        #1 chk("f_tready", t2ready, 1'b1);
        @(negedge ap_clk);
        t2valid = 1'b0;
        #1;
        chk("f_tvalid", o2valid, 1'b1);
        chk("f_tdata", o2data, 32'h1234_5678);
        chk("f_tdest", o2dest, 1'b0);
        @(negedge ap_clk);
        o2rdy   = 1'b0;
        t2valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("f%0d_tready", k), t2ready, (k < 2) ? 1'b1 : 1'b0);
            chk($sformatf("f%0d_count", k), cnt2, (k < 2) ? 2'(k) : 2'd2);
            @(negedge ap_clk);
        end
        t2valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_mux.md
Name: sync_mux

Overview:
- Parametrised successor of the single-channel sync PE.
- Accepts task beats from NUM_CH AXI-Stream task inputs and arbitrates among them round-robin.
- Extracts a configurable argument field from each accepted beat and buffers it in a small FIFO.
- Emits the field on one AXI-Stream argOut, tagged with the source channel in TDEST.
- Sits between the scheduler's sync-task queues and the argument-return network. Multiple sync producers share one return port, with correct valid/ready back-pressure.

Parameters:
- NUM_CH, 4, number of taskIn channels (>=1).
- TASK_W, 128, width of one taskIn beat.
- ARG_W, 64, width of the extracted argument.
- ARG_LSB, 64, bit offset of the argument inside a task beat. ARG_LSB+ARG_W <= TASK_W.
- FIFO_DEPTH, 4, output FIFO entries. Power of two, >=2.

Ports:
- ap_clk  in  1  clock, all logic on rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- taskIn_TDATA  in  NUM_CH*TASK_W  channel i occupies bits [i*TASK_W +: TASK_W].
- taskIn_TVALID  in  NUM_CH  per-channel valid.
- taskIn_TREADY  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- argOut_TDATA  out  ARG_W  extracted argument (FIFO head).
- argOut_TDEST  out  CH_W  source channel of head entry; CH_W = max(1,clog2(NUM_CH)).
- argOut_TVALID  out  1  FIFO non-empty.
- argOut_TREADY  in  1  downstream ready.
- fifo_count  out  clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (ap_rst high, async):
  - FIFO empty; rd/wr pointers 0.
  - RR priority pointer 0.
  - argOut_TVALID=0, argOut_TDATA=0, argOut_TDEST=0, fifo_count=0.
  - taskIn_TREADY forced all-0 while ap_rst high.
  - Reset mid-operation discards buffered entries. No partial beat is emitted after release.
- Arbitration:
  - Combinational grant over taskIn_TVALID, starting search at priority pointer p and wrapping NUM_CH-1 -> 0.
  - taskIn_TREADY = grant one-hot AND (fifo_count != FIFO_DEPTH).
  - TREADY may depend on TVALID but never on argOut_TREADY; there is no combinational path from argOut_TREADY.
  - On accept from channel g: p <= (g+1) mod NUM_CH. With no accept, p holds.
- Push:
  - Entry = {g, taskIn_TDATA[g*TASK_W+ARG_LSB +: ARG_W]}, written at wr_ptr.
  - wr_ptr increments mod FIFO_DEPTH.
- Pop: when argOut_TVALID && argOut_TREADY, rd_ptr increments mod FIFO_DEPTH.
- Outputs:
  - argOut_TDATA/TDEST driven from storage at rd_ptr (first-word-fall-through).
  - argOut_TVALID = (fifo_count != 0).
  - argOut_TDATA/TDEST are held stable while TVALID && !TREADY.
- Latency: a beat accepted in cycle n is visible on argOut in cycle n+1 if the FIFO was empty.
- Throughput: 1 beat/cycle sustained when downstream is always ready.
- Count: fifo_count += push - pop. Simultaneous push and pop leaves the count unchanged.
- Full: fifo_count == FIFO_DEPTH gives all TREADY=0, even if a pop occurs in the same cycle. The freed slot is usable from the next cycle.
- Empty: argOut_TVALID=0; argOut_TREADY is ignored.
- NUM_CH=1: arbiter degenerates to a pass-through; TDEST constant 0.

Decomposition:
- Package sync_pkg holds:
  - entry struct {dest, arg};
  - width helpers CH_W and CNT_W;
  - default parameter constants.
- Sub-module sync_rr_arbiter (NUM_CH): request vector and enable in; one-hot grant and index out. The pointer register lives inside it, updated on enable&&|req.
- The FIFO is inline in sync_mux.

Test Plan:
- Single-channel pass: ch0 sends beat with TDATA[127:64]=64'hDEAD_BEEF_0000_0001, argOut_TREADY=1.
  -> ch0 TREADY=1 that cycle.
  -> next cycle argOut_TVALID=1, TDATA=64'hDEAD_BEEF_0000_0001, TDEST=0.
- Round-robin fairness: all 4 channels continuously valid, payload=channel id, downstream ready.
  -> TDEST sequence 0,1,2,3,0,1,...
  -> exactly one TREADY per cycle.
- Back-pressure/full: argOut_TREADY=0, ch2 valid for 6 cycles.
  -> 4 accepts, fifo_count=4, then TREADY=0.
  -> argOut holds first entry stable.
  -> raising TREADY for 1 cycle pops 1; ch2 accepted the following cycle.
- Simultaneous push/pop: fifo_count=2, push and pop in the same cycle.
  -> fifo_count stays 2; FIFO order preserved across wr/rd pointer wrap after 10 ops.
- Async reset mid-stream: ap_rst asserted between clock edges with fifo_count=3.
  -> argOut_TVALID=0, fifo_count=0, all TREADY=0 immediately.
  -> after release, first grant goes to ch0.
- Field offset: TASK_W=96, ARG_W=32, ARG_LSB=16, beat 96'h...._1234_5678_9ABC.
  -> argOut_TDATA=32'h1234_5678.
